// File: rtl/mmu_client.sv
// mmu_client: tags user alloc/free commands, pushes them into the MMU request
// FIFOs, tracks in-flight requests in a per-tag table and matches responses
// from the two FWFT response FIFOs back to a single completion register.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 3
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module mmu_client #(
  parameter int TAG_WIDTH = 3  // must not exceed `REQ_ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_is_free,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0]    cmd_page_idx,
  input  logic [`REQ_SIZE_TYPE_WIDTH-1:0]   cmd_page_count,
  output logic                              alloc_req_write_en,
  output logic [`REQ_ID_WIDTH-1:0]          alloc_req_id,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0]   alloc_req_page_count,
  input  logic                              alloc_req_fifo_almost_full,
  output logic                              free_req_write_en,
  output logic [`REQ_ID_WIDTH-1:0]          free_req_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0]    free_req_page_idx,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0]   free_req_page_count,
  input  logic                              free_req_fifo_almost_full,
  output logic                              alloc_rsp_pop,
  input  logic [`REQ_ID_WIDTH-1:0]          alloc_rsp_id,
  input  logic [`ALL_PAGE_IDX_WIDTH-1:0]    alloc_rsp_page_idx,
  input  logic                              alloc_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]     alloc_rsp_fail_reason,
  input  logic                              alloc_rsp_fifo_empty,
  output logic                              free_rsp_pop,
  input  logic [`REQ_ID_WIDTH-1:0]          free_rsp_id,
  input  logic                              free_rsp_fail,
  input  logic [`FAIL_REASON_WIDTH-1:0]     free_rsp_fail_reason,
  input  logic                              free_rsp_fifo_empty,
  output logic                              done_valid,
  input  logic                              done_ready,
  output logic                              done_is_free,
  output logic [`REQ_ID_WIDTH-1:0]          done_id,
  output logic [`ALL_PAGE_IDX_WIDTH-1:0]    done_page_idx,
  output logic [`REQ_SIZE_TYPE_WIDTH-1:0]   done_page_count,
  output logic                              done_fail,
  output logic [`FAIL_REASON_WIDTH-1:0]     done_fail_reason,
  output logic                              spurious_rsp,
  output logic [TAG_WIDTH:0]                outstanding_count
);
  localparam int DEPTH = 1 << TAG_WIDTH;

  logic [`REQ_ID_WIDTH-1:0]        id_reg;
  logic [DEPTH-1:0]                tbl_valid_reg;
  logic [DEPTH-1:0]                tbl_is_free_reg;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0] tbl_count_reg [DEPTH];
  logic [`ALL_PAGE_IDX_WIDTH-1:0]  tbl_page_reg  [DEPTH];
  logic                            rr_free_reg;     // 1: free wins next tie
  logic [TAG_WIDTH:0]              outstanding_reg;

  logic                            alloc_we_reg, free_we_reg;
  logic [`REQ_ID_WIDTH-1:0]        req_id_reg;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]  req_page_reg;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0] req_count_reg;

  logic                            done_valid_reg, done_is_free_reg, done_fail_reg;
  logic [`REQ_ID_WIDTH-1:0]        done_id_reg;
  logic [`ALL_PAGE_IDX_WIDTH-1:0]  done_page_reg;
  logic [`REQ_SIZE_TYPE_WIDTH-1:0] done_count_reg;
  logic [`FAIL_REASON_WIDTH-1:0]   done_reason_reg;
  logic                            spurious_reg;

  // Command side: a tag is reusable only once its table entry has retired.
  logic [TAG_WIDTH-1:0] cmd_tag;
  logic                 accept;
  assign cmd_tag   = id_reg[TAG_WIDTH-1:0];
  assign cmd_ready = !rst && !tbl_valid_reg[cmd_tag] &&
                     !(cmd_is_free ? free_req_fifo_almost_full : alloc_req_fifo_almost_full);
  assign accept    = cmd_valid && cmd_ready;

  // Response side: pop only when the completion register can take the result.
  logic                           can_pop, alloc_elig, free_elig, pick_free, popped, rsp_hit;
  logic [`REQ_ID_WIDTH-1:0]       rsp_id;
  logic [TAG_WIDTH-1:0]           rsp_tag;
  assign can_pop       = !rst && (!done_valid_reg || done_ready);
  assign alloc_elig    = can_pop && !alloc_rsp_fifo_empty;
  assign free_elig     = can_pop && !free_rsp_fifo_empty;
  assign pick_free     = free_elig && (!alloc_elig || rr_free_reg);
  assign alloc_rsp_pop = alloc_elig && !pick_free;
  assign free_rsp_pop  = pick_free;
  assign popped        = alloc_rsp_pop || free_rsp_pop;
  assign rsp_id        = pick_free ? free_rsp_id : alloc_rsp_id;
  assign rsp_tag       = rsp_id[TAG_WIDTH-1:0];
  // A response retires its tag only if the entry is live and of the same kind.
  assign rsp_hit       = popped && tbl_valid_reg[rsp_tag] && (tbl_is_free_reg[rsp_tag] == pick_free);

  // ID counter, tag table valid bits, round-robin pointer and in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_reg          <= '0;
      tbl_valid_reg   <= '0;
      rr_free_reg     <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      if (accept) begin
        id_reg                 <= id_reg + 1'b1;
        tbl_valid_reg[cmd_tag] <= 1'b1;
      end
      // accept and retire never touch the same tag (valid must be 0 vs 1)
      if (rsp_hit)
        tbl_valid_reg[rsp_tag] <= 1'b0;
      if (alloc_elig && free_elig)
        rr_free_reg <= !pick_free;
      outstanding_reg <= outstanding_reg + (TAG_WIDTH+1)'(accept) - (TAG_WIDTH+1)'(rsp_hit);
    end
  end

  // Table payload: written on acceptance, needs no reset since valid gates it.
  always_ff @(posedge clk) begin
    if (accept) begin
      tbl_is_free_reg[cmd_tag] <= cmd_is_free;
      tbl_count_reg[cmd_tag]   <= cmd_page_count;
      tbl_page_reg[cmd_tag]    <= cmd_page_idx;
    end
  end

  // Registered request pushes: one-cycle write enable with the accepted payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_we_reg  <= 1'b0;
      free_we_reg   <= 1'b0;
      req_id_reg    <= '0;
      req_page_reg  <= '0;
      req_count_reg <= '0;
    end else begin
      alloc_we_reg <= accept && !cmd_is_free;
      free_we_reg  <= accept && cmd_is_free;
      if (accept) begin
        req_id_reg    <= id_reg;
        req_page_reg  <= cmd_page_idx;
        req_count_reg <= cmd_page_count;
      end
    end
  end

  // Completion register and spurious-response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid_reg   <= 1'b0;
      done_is_free_reg <= 1'b0;
      done_id_reg      <= '0;
      done_page_reg    <= '0;
      done_count_reg   <= '0;
      done_fail_reg    <= 1'b0;
      done_reason_reg  <= '0;
      spurious_reg     <= 1'b0;
    end else begin
      spurious_reg <= popped && !rsp_hit;
      if (rsp_hit) begin
        done_valid_reg   <= 1'b1;
        done_is_free_reg <= pick_free;
        done_id_reg      <= rsp_id;
        done_page_reg    <= pick_free ? tbl_page_reg[rsp_tag] : alloc_rsp_page_idx;
        done_count_reg   <= tbl_count_reg[rsp_tag];
        done_fail_reg    <= pick_free ? free_rsp_fail : alloc_rsp_fail;
        done_reason_reg  <= pick_free ? free_rsp_fail_reason : alloc_rsp_fail_reason;
      end else if (done_ready) begin
        done_valid_reg <= 1'b0;
      end
    end
  end

  assign alloc_req_write_en   = alloc_we_reg;
  assign alloc_req_id         = req_id_reg;
  assign alloc_req_page_count = req_count_reg;
  assign free_req_write_en    = free_we_reg;
  assign free_req_id          = req_id_reg;
  assign free_req_page_idx    = req_page_reg;
  assign free_req_page_count  = req_count_reg;
  assign done_valid           = done_valid_reg;
  assign done_is_free         = done_is_free_reg;
  assign done_id              = done_id_reg;
  assign done_page_idx        = done_page_reg;
  assign done_page_count      = done_count_reg;
  assign done_fail            = done_fail_reg;
  assign done_fail_reason     = done_reason_reg;
  assign spurious_rsp         = spurious_reg;
  assign outstanding_count    = outstanding_reg;
endmodule

// File: tb/tb_mmu_client.sv
// tb_mmu_client: directed scenarios followed by randomized traffic, all checked
// against a transaction-level model of tag allocation and response matching.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 3
`endif
`ifndef FAIL_REASON_WIDTH
`define FAIL_REASON_WIDTH 2
`endif

module tb_mmu_client;
  localparam int TW   = 3;
  localparam int NTAG = 1 << TW;
  localparam int IW   = `REQ_ID_WIDTH;
  localparam int PW   = `ALL_PAGE_IDX_WIDTH;
  localparam int CW   = `REQ_SIZE_TYPE_WIDTH;
  localparam int RW   = `FAIL_REASON_WIDTH;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_is_free = 1'b0;
  logic [PW-1:0] cmd_page_idx = '0;
  logic [CW-1:0] cmd_page_count = '0;
  logic alloc_req_write_en, free_req_write_en;
  logic [IW-1:0] alloc_req_id, free_req_id;
  logic [CW-1:0] alloc_req_page_count, free_req_page_count;
  logic [PW-1:0] free_req_page_idx;
  logic alloc_af = 1'b0, free_af = 1'b0;
  logic alloc_rsp_pop, free_rsp_pop;
  logic [IW-1:0] alloc_rsp_id = '0, free_rsp_id = '0;
  logic [PW-1:0] alloc_rsp_page_idx = '0;
  logic alloc_rsp_fail = 1'b0, free_rsp_fail = 1'b0;
  logic [RW-1:0] alloc_rsp_fail_reason = '0, free_rsp_fail_reason = '0;
  logic alloc_rsp_fifo_empty = 1'b1, free_rsp_fifo_empty = 1'b1;
  logic done_valid, done_ready = 1'b1, done_is_free, done_fail, spurious_rsp;
  logic [IW-1:0] done_id;
  logic [PW-1:0] done_page_idx;
  logic [CW-1:0] done_page_count;
  logic [RW-1:0] done_fail_reason;
  logic [TW:0]   outstanding_count;

  mmu_client #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_free(cmd_is_free),
    .cmd_page_idx(cmd_page_idx), .cmd_page_count(cmd_page_count),
    .alloc_req_write_en(alloc_req_write_en), .alloc_req_id(alloc_req_id),
    .alloc_req_page_count(alloc_req_page_count), .alloc_req_fifo_almost_full(alloc_af),
    .free_req_write_en(free_req_write_en), .free_req_id(free_req_id),
    .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
    .free_req_fifo_almost_full(free_af),
    .alloc_rsp_pop(alloc_rsp_pop), .alloc_rsp_id(alloc_rsp_id),
    .alloc_rsp_page_idx(alloc_rsp_page_idx), .alloc_rsp_fail(alloc_rsp_fail),
    .alloc_rsp_fail_reason(alloc_rsp_fail_reason), .alloc_rsp_fifo_empty(alloc_rsp_fifo_empty),
    .free_rsp_pop(free_rsp_pop), .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
    .free_rsp_fail_reason(free_rsp_fail_reason), .free_rsp_fifo_empty(free_rsp_fifo_empty),
    .done_valid(done_valid), .done_ready(done_ready), .done_is_free(done_is_free),
    .done_id(done_id), .done_page_idx(done_page_idx), .done_page_count(done_page_count),
    .done_fail(done_fail), .done_fail_reason(done_fail_reason),
    .spurious_rsp(spurious_rsp), .outstanding_count(outstanding_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; logic [PW-1:0] idx; logic fail; logic [RW-1:0] reason; } rsp_t;
  typedef struct { logic [IW-1:0] id; logic is_free; } pend_t;
  typedef struct { logic is_free; logic [IW-1:0] id; logic [PW-1:0] idx; logic [CW-1:0] cnt;
                   logic fail; logic [RW-1:0] reason; } done_t;

  rsp_t  aq[$], fq[$];   // contents of the two response FIFOs
  pend_t pend[$];        // accepted requests not yet answered

  // reference model state
  bit            m_valid [NTAG];
  bit            m_isf   [NTAG];
  logic [CW-1:0] m_cnt   [NTAG];
  logic [PW-1:0] m_idx   [NTAG];
  logic [IW-1:0] m_id;
  int            m_out;
  bit            m_free_next;   // next tie goes to the free FIFO
  bit            m_dv;
  done_t         md;
  bit            e_awe, e_fwe, e_spur;
  logic [IW-1:0] e_rid;
  logic [PW-1:0] e_ridx;
  logic [CW-1:0] e_rcnt;
  logic          last_apop, last_fpop;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_heads();
    alloc_rsp_fifo_empty = (aq.size() == 0);
    free_rsp_fifo_empty  = (fq.size() == 0);
    if (aq.size() > 0) begin
      alloc_rsp_id = aq[0].id; alloc_rsp_page_idx = aq[0].idx;
      alloc_rsp_fail = aq[0].fail; alloc_rsp_fail_reason = aq[0].reason;
    end
    if (fq.size() > 0) begin
      free_rsp_id = fq[0].id; free_rsp_fail = fq[0].fail; free_rsp_fail_reason = fq[0].reason;
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < NTAG; t++) m_valid[t] = 0;
    m_id = '0; m_out = 0; m_free_next = 0; m_dv = 0;
    e_awe = 0; e_fwe = 0; e_spur = 0;
  endtask

  // one clock cycle; inputs are set by the caller at posedge+1
  task automatic cycle();
    bit exp_ready, can_pop, ea, ef, sel_free, hit;
    rsp_t r;
    logic [TW-1:0] t;
    drive_heads();
    #1;
    check("alloc_we", alloc_req_write_en, e_awe);
    check("free_we", free_req_write_en, e_fwe);
    if (e_awe) begin
      check("alloc_id", alloc_req_id, e_rid);
      check("alloc_cnt", alloc_req_page_count, e_rcnt);
    end
    if (e_fwe) begin
      check("free_id", free_req_id, e_rid);
      check("free_idx", free_req_page_idx, e_ridx);
      check("free_cnt", free_req_page_count, e_rcnt);
    end
    check("spurious", spurious_rsp, e_spur);
    check("done_valid", done_valid, m_dv);
    if (m_dv) begin
      check("done_is_free", done_is_free, md.is_free);
      check("done_id", done_id, md.id);
      check("done_idx", done_page_idx, md.idx);
      check("done_cnt", done_page_count, md.cnt);
      check("done_fail", done_fail, md.fail);
      check("done_reason", done_fail_reason, md.reason);
    end
    check("outstanding", outstanding_count, m_out);
    exp_ready = !m_valid[m_id[TW-1:0]] && !(cmd_is_free ? free_af : alloc_af);
    check("cmd_ready", cmd_ready, exp_ready);
    can_pop  = !m_dv || done_ready;
    ea       = can_pop && aq.size() > 0;
    ef       = can_pop && fq.size() > 0;
    sel_free = ef && (!ea || m_free_next);
    check("alloc_pop", alloc_rsp_pop, ea && !sel_free);
    check("free_pop", free_rsp_pop, sel_free);
    last_apop = alloc_rsp_pop; last_fpop = free_rsp_pop;

    // what the next edge should do
    e_awe = 0; e_fwe = 0; e_spur = 0;
    if (m_dv && done_ready) m_dv = 0;
    if (ea || ef) begin
      r   = sel_free ? fq.pop_front() : aq.pop_front();
      t   = r.id[TW-1:0];
      hit = m_valid[t] && (m_isf[t] == sel_free);
      if (hit) begin
        m_dv = 1;
        md.is_free = sel_free; md.id = r.id; md.cnt = m_cnt[t];
        md.idx = sel_free ? m_idx[t] : r.idx;
        md.fail = r.fail; md.reason = r.reason;
        m_valid[t] = 0; m_out--;
      end else begin
        e_spur = 1;
      end
      if (ea && ef) m_free_next = !sel_free;
    end
    if (cmd_valid && exp_ready) begin
      t = m_id[TW-1:0];
      m_valid[t] = 1; m_isf[t] = cmd_is_free; m_cnt[t] = cmd_page_count; m_idx[t] = cmd_page_idx;
      e_awe = !cmd_is_free; e_fwe = cmd_is_free;
      e_rid = m_id; e_ridx = cmd_page_idx; e_rcnt = cmd_page_count;
      pend.push_back('{id: m_id, is_free: cmd_is_free});
      m_id = m_id + 1'b1; m_out++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; cmd_valid = 1; cmd_is_free = 0; alloc_af = 0; free_af = 0; done_ready = 1;
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_alloc_pop", alloc_rsp_pop, 0);
    check("rst_free_pop", free_rsp_pop, 0);
    check("rst_alloc_we", alloc_req_write_en, 0);
    check("rst_free_we", free_req_write_en, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_spurious", spurious_rsp, 0);
    check("rst_outstanding", outstanding_count, 0);
    model_clear();
    rst = 0; cmd_valid = 0;
  endtask

  task automatic respond(input logic [IW-1:0] id, input bit is_free, input logic [PW-1:0] idx);
    rsp_t r;
    r = '{id: id, idx: idx, fail: 1'b0, reason: '0};
    for (int k = 0; k < pend.size(); k++)
      if (pend[k].id == id && pend[k].is_free == is_free) begin pend.delete(k); break; end
    if (is_free) fq.push_back(r); else aq.push_back(r);
  endtask

  initial begin
    model_clear();
    do_reset();

    // single alloc round trip
    cmd_valid = 1; cmd_is_free = 0; cmd_page_count = 2; cmd_page_idx = 0;
    cycle();
    check("t1_we", alloc_req_write_en, 1);
    check("t1_id", alloc_req_id, 0);
    cmd_valid = 0;
    respond(0, 0, 5);
    cycle();
    check("t1_done_valid", done_valid, 1);
    check("t1_done_id", done_id, 0);
    check("t1_done_idx", done_page_idx, 5);
    check("t1_outstanding", outstanding_count, 0);

    // fill all eight tags, then free one
    cmd_valid = 1; cmd_page_count = 1;
    repeat (8) cycle();
    check("t2_full", cmd_ready, 0);
    respond(1, 0, 7);
    cycle();
    cmd_valid = 0;
    check("t2_ready_after_retire", cmd_ready, 1);
    cycle();

    // round-robin: alloc first after reset, then alternate
    respond(2, 0, 20); respond(3, 0, 21);
    fq.push_back('{id: 8'd4, idx: '0, fail: 1'b1, reason: 2'd1});
    fq.push_back('{id: 8'd4, idx: '0, fail: 1'b0, reason: 2'd2});
    for (int k = 0; k < 4; k++) begin
      logic exp_a;
      exp_a = (k % 2 == 0);
      cycle();
      check("rr_alloc_pop", last_apop, exp_a);
      check("rr_free_pop", last_fpop, !exp_a);
    end

    // free response for a tag that is not outstanding
    fq.push_back('{id: 8'd3, idx: '0, fail: 1'b0, reason: '0});
    cycle();
    check("t4_free_pop", last_fpop, 1);
    check("t4_spurious", spurious_rsp, 1);
    check("t4_done_valid", done_valid, 0);
    cycle();
    check("t4_free_pop_once", last_fpop, 0);
    check("t4_spurious_once", spurious_rsp, 0);

    // completion held while done_ready is low
    respond(4, 0, 9);
    cycle();
    done_ready = 0;
    respond(5, 0, 11);
    repeat (5) begin
      cycle();
      check("t5_hold_idx", done_page_idx, 9);
      check("t5_no_pop", last_apop, 0);
    end
    done_ready = 1;

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      cmd_valid      = ($urandom_range(0, 9) < 6);
      cmd_is_free    = $urandom_range(0, 1);
      cmd_page_idx   = PW'($urandom);
      cmd_page_count = CW'($urandom);
      alloc_af       = ($urandom_range(0, 4) == 0);
      free_af        = ($urandom_range(0, 4) == 0);
      done_ready     = ($urandom_range(0, 9) < 7);
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        int k;
        rsp_t r;
        k = $urandom_range(0, pend.size() - 1);
        r = '{id: pend[k].id, idx: PW'($urandom), fail: 1'($urandom), reason: RW'($urandom)};
        if (pend[k].is_free) fq.push_back(r); else aq.push_back(r);
        pend.delete(k);
      end
      if ($urandom_range(0, 39) == 0) begin
        rsp_t r;
        r = '{id: IW'($urandom), idx: PW'($urandom), fail: 1'($urandom), reason: RW'($urandom)};
        if ($urandom_range(0, 1) == 1) fq.push_back(r); else aq.push_back(r);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
